bcd_time_core: RTL and testbench

//   Parametrised timekeeping core for the watch: counts ticks of clk1sec into minutes and hours.

---
 rtl/bcd_time_core.sv | 199 +++++++++++++++++++
 tb/tb_bcd_time_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_core.sv
// bcd_time_core
//   Timekeeping core for the watch. Counts clk1sec ticks into minutes and
//   hours, decodes hours/minutes into four BCD display digits (12h or 24h),
//   and handles button-driven time/alarm setting plus a timed alarm output.
//
// Ports
//   clk1sec      in   tick clock, all state updates on its rising edge
//   rst          in   asynchronous, active-high reset
//   sel[1:0]     in   00 set time, 01 set alarm (and show alarm), 1x run
//   minbtn       in   +1 minute per cycle while held (no hour carry)
//   tenminbtn    in   +10 minutes per cycle while held (no hour carry)
//   hrbtn        in   +1 hour per cycle while held
//   clrbtn       in   in sel=00, load the reset time
//   alarm_en     in   arms the alarm; low cancels an active alarm
//   tenhrout     out  BCD tens of displayed hour
//   onehrout     out  BCD units of displayed hour
//   tenminout    out  BCD tens of displayed minute
//   oneminout    out  BCD units of displayed minute
//   sec[7:0]     out  tick count within the current minute
//   pm           out  displayed hour >= 12 (12h mode only)
//   minute_pulse out  one cycle high after each natural minute rollover
//   alarm_out    out  alarm active
`timescale 1ns/1ps

module bcd_time_core #(
    parameter int unsigned TICKS_PER_MIN  = 60,
    parameter int unsigned HOUR_MODE_24   = 0,
    parameter int unsigned RST_HOUR       = 12,
    parameter int unsigned RST_MIN        = 0,
    parameter int unsigned RST_ALARM_HOUR = 6,
    parameter int unsigned ALARM_LEN      = 30
) (
    input  logic       clk1sec,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       minbtn,
    input  logic       tenminbtn,
    input  logic       hrbtn,
    input  logic       clrbtn,
    input  logic       alarm_en,
    output logic [3:0] tenhrout,
    output logic [3:0] onehrout,
    output logic [3:0] tenminout,
    output logic [3:0] oneminout,
    output logic [7:0] sec,
    output logic       pm,
    output logic       minute_pulse,
    output logic       alarm_out
);

    localparam logic [7:0] LAST_TICK  = 8'(TICKS_PER_MIN - 1);
    localparam logic [7:0] ALARM_CNT  = 8'(ALARM_LEN);
    localparam logic [4:0] RST_HR_V   = 5'(RST_HOUR);
    localparam logic [5:0] RST_MN_V   = 6'(RST_MIN);
    localparam logic [4:0] RST_AL_HR  = 5'(RST_ALARM_HOUR);

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_CLR,
        ACT_HR,
        ACT_TEN,
        ACT_MIN
    } action_t;

    logic [4:0] hr, al_hr;
    logic [5:0] mn, al_mn;
    logic [7:0] alarm_cnt;

    action_t    act;
    logic       time_set, alarm_set, rollover, fire, cancel;
    logic [4:0] nat_hr;
    logic [5:0] nat_mn;

    function automatic logic [5:0] inc_min(input logic [5:0] m);
        return (m == 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    // Ten-minute step wraps within the hour and keeps the units digit.
    function automatic logic [5:0] add_ten(input logic [5:0] m);
        return (m >= 6'd50) ? m - 6'd50 : m + 6'd10;
    endfunction

    function automatic logic [4:0] inc_hr(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens, ones;
        tens = 4'(v / 6'd10);
        ones = 4'(v % 6'd10);
        return {tens, ones};
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        act = ACT_NONE;
        if (clrbtn && sel == 2'b00) act = ACT_CLR;
        else if (hrbtn)             act = ACT_HR;
        else if (tenminbtn)         act = ACT_TEN;
        else if (minbtn)            act = ACT_MIN;

        time_set  = (sel == 2'b00) && (act != ACT_NONE);
        alarm_set = (sel == 2'b01) && (act != ACT_NONE);

        // A time-set cycle suppresses the natural advance entirely.
        rollover = !time_set && (sec == LAST_TICK);
        nat_mn   = inc_min(mn);
        nat_hr   = (mn == 6'd59) ? inc_hr(hr) : hr;

        fire   = rollover && alarm_en && (nat_hr == al_hr) && (nat_mn == al_mn);
        cancel = minbtn || tenminbtn || hrbtn || clrbtn || !alarm_en;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk1sec or posedge rst) begin
        if (rst) begin
            hr           <= RST_HR_V;
            mn           <= RST_MN_V;
            al_hr        <= RST_AL_HR;
            al_mn        <= 6'd0;
            sec          <= 8'd0;
            minute_pulse <= 1'b0;
            alarm_out    <= 1'b0;
            alarm_cnt    <= 8'd0;
        end else begin
            if (time_set) begin
                case (act)
                    ACT_CLR: begin
                        hr <= RST_HR_V;
                        mn <= RST_MN_V;
                    end
                    ACT_HR:  hr <= inc_hr(hr);
                    ACT_TEN: mn <= add_ten(mn);
                    ACT_MIN: mn <= inc_min(mn);
                    default: ;
                endcase
                sec          <= 8'd0;
                minute_pulse <= 1'b0;
            end else if (rollover) begin
                sec          <= 8'd0;
                mn           <= nat_mn;
                hr           <= nat_hr;
                minute_pulse <= 1'b1;
            end else begin
                sec          <= sec + 8'd1;
                minute_pulse <= 1'b0;
            end

            if (alarm_set) begin
                case (act)
                    ACT_HR:  al_hr <= inc_hr(al_hr);
                    ACT_TEN: al_mn <= add_ten(al_mn);
                    ACT_MIN: al_mn <= inc_min(al_mn);
                    default: ;
                endcase
            end

            // Cancel wins over a coincident trigger; the counter reaching
            // zero drops alarm_out, giving exactly ALARM_LEN high cycles.
            if (cancel) begin
                alarm_out <= 1'b0;
                alarm_cnt <= 8'd0;
            end else if (fire) begin
                alarm_out <= 1'b1;
                alarm_cnt <= ALARM_CNT;
            end else if (alarm_out) begin
                alarm_cnt <= alarm_cnt - 8'd1;
                if (alarm_cnt == 8'd1) alarm_out <= 1'b0;
            end
        end
    end

    // Display decode: purely combinational from the registers.
    logic [4:0] disp_hr, shown_hr;
    logic [5:0] disp_mn;
    logic [7:0] hr_bcd, mn_bcd;

    always_comb begin
        disp_hr  = (sel == 2'b01) ? al_hr : hr;
        disp_mn  = (sel == 2'b01) ? al_mn : mn;
        shown_hr = disp_hr;
        pm       = 1'b0;
        if (HOUR_MODE_24 == 0) begin
            pm = (disp_hr >= 5'd12);
            if (disp_hr >= 5'd12) shown_hr = disp_hr - 5'd12;
            if (shown_hr == 5'd0) shown_hr = 5'd12;
        end
        hr_bcd = to_bcd({1'b0, shown_hr});
        mn_bcd = to_bcd(disp_mn);
    end

    assign tenhrout  = hr_bcd[7:4];
    assign onehrout  = hr_bcd[3:0];
    assign tenminout = mn_bcd[7:4];
    assign oneminout = mn_bcd[3:0];

endmodule

// File: tb/tb_bcd_time_core.sv
// tb_bcd_time_core
//   Directed bench for bcd_time_core. Two instances share all inputs: one in
//   12h mode (defaults) and one in 24h mode, so both decodes see the same
//   register state. Inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_bcd_time_core;

    logic       clk1sec = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       minbtn, tenminbtn, hrbtn, clrbtn, alarm_en;

    logic [3:0] th12, oh12, tm12, om12, th24, oh24, tm24, om24;
    logic [7:0] sec12, sec24;
    logic       pm12, pm24, mp12, mp24, al12, al24;

    int checks = 0;
    int errors = 0;

    // Button vectors, ordered {clrbtn, hrbtn, tenminbtn, minbtn}.
    localparam logic [3:0] B_CLR = 4'b1000;
    localparam logic [3:0] B_HR  = 4'b0100;
    localparam logic [3:0] B_TEN = 4'b0010;
    localparam logic [3:0] B_MIN = 4'b0001;

    always #5 clk1sec = ~clk1sec;

    bcd_time_core u_dut12 (
        .clk1sec(clk1sec), .rst(rst), .sel(sel),
        .minbtn(minbtn), .tenminbtn(tenminbtn), .hrbtn(hrbtn), .clrbtn(clrbtn),
        .alarm_en(alarm_en),
        .tenhrout(th12), .onehrout(oh12), .tenminout(tm12), .oneminout(om12),
        .sec(sec12), .pm(pm12), .minute_pulse(mp12), .alarm_out(al12)
    );

    bcd_time_core #(.HOUR_MODE_24(1)) u_dut24 (
        .clk1sec(clk1sec), .rst(rst), .sel(sel),
        .minbtn(minbtn), .tenminbtn(tenminbtn), .hrbtn(hrbtn), .clrbtn(clrbtn),
        .alarm_en(alarm_en),
        .tenhrout(th24), .onehrout(oh24), .tenminout(tm24), .oneminout(om24),
        .sec(sec24), .pm(pm24), .minute_pulse(mp24), .alarm_out(al24)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected digits written as hex so 16'h1159 reads as 11:59.
    task automatic check12(input string tag, input logic [15:0] digits, input logic exp_pm);
        check({tag, " digits12"}, {16'h0, th12, oh12, tm12, om12}, {16'h0, digits});
        check({tag, " pm12"}, {31'h0, pm12}, {31'h0, exp_pm});
    endtask

    task automatic check24(input string tag, input logic [15:0] digits);
        check({tag, " digits24"}, {16'h0, th24, oh24, tm24, om24}, {16'h0, digits});
        check({tag, " pm24"}, {31'h0, pm24}, 32'h0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk1sec);
    endtask

    task automatic hold(input logic [1:0] s, input logic [3:0] b, input int n);
        sel = s;
        {clrbtn, hrbtn, tenminbtn, minbtn} = b;
        tick(n);
        {clrbtn, hrbtn, tenminbtn, minbtn} = 4'b0000;
    endtask

    // Clear to 12:00, then step hours/tens/units up to h:m; leaves sel in run.
    task automatic set_time(input int h, input int m);
        hold(2'b00, B_CLR, 1);
        hold(2'b00, B_HR, (h + 12) % 24);
        hold(2'b00, B_TEN, m / 10);
        hold(2'b00, B_MIN, m % 10);
        sel = 2'b10;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        sel = 2'b10;
        {clrbtn, hrbtn, tenminbtn, minbtn} = 4'b0000;
        alarm_en = 1'b0;

        // Reset state
        #1;
        check12("reset", 16'h1200, 1'b1);
        check24("reset", 16'h1200);
        check("reset sec", {24'h0, sec12}, 32'd0);
        check("reset pulse", {31'h0, mp12}, 32'd0);
        check("reset alarm", {31'h0, al12}, 32'd0);
        @(negedge clk1sec);
        rst = 1'b0;

        // Rollover 11:59 -> 12:00 pm
        set_time(11, 59);
        check12("pre 1159", 16'h1159, 1'b0);
        check("pre 1159 sec", {24'h0, sec12}, 32'd0);
        tick(59);
        check("tick59 sec", {24'h0, sec12}, 32'd59);
        check12("tick59", 16'h1159, 1'b0);
        check("tick59 pulse", {31'h0, mp12}, 32'd0);
        tick(1);
        check12("roll 1200", 16'h1200, 1'b1);
        check24("roll 1200", 16'h1200);
        check("roll pulse", {31'h0, mp12}, 32'd1);
        check("roll sec", {24'h0, sec12}, 32'd0);
        tick(1);
        check("pulse drop", {31'h0, mp12}, 32'd0);
        check("sec after roll", {24'h0, sec12}, 32'd1);

        // Rollover 23:59 -> midnight
        set_time(23, 59);
        check12("pre 2359", 16'h1159, 1'b1);
        check24("pre 2359", 16'h2359);
        tick(60);
        check12("midnight", 16'h1200, 1'b0);
        check24("midnight", 16'h0000);

        // Set time: hour steps clear sec
        hold(2'b00, B_CLR, 1);
        sel = 2'b10;
        tick(5);
        check("run sec5", {24'h0, sec12}, 32'd5);
        hold(2'b00, B_HR, 3);
        check12("hr x3", 16'h0300, 1'b1);
        check24("hr x3", 16'h1500);
        check("hr x3 sec", {24'h0, sec12}, 32'd0);

        // Ten-minute step wraps without hour carry
        hold(2'b00, B_CLR, 1);
        hold(2'b00, B_MIN, 7);
        hold(2'b00, B_TEN, 5);
        check24("1257", 16'h1257);
        hold(2'b00, B_TEN, 1);
        check12("ten wrap", 16'h1207, 1'b1);
        check24("ten wrap", 16'h1207);

        // hrbtn beats minbtn
        hold(2'b00, B_HR | B_MIN, 1);
        check12("hr+min", 16'h0107, 1'b1);
        check24("hr+min", 16'h1307);

        // Run mode ignores set buttons
        hold(2'b10, B_CLR | B_HR | B_TEN | B_MIN, 5);
        check24("run btns", 16'h1307);
        check("run btns sec", {24'h0, sec12}, 32'd5);

        // Alarm set: alarm display changes, time keeps running
        hold(2'b01, B_MIN, 1);
        check12("alarm 0601", 16'h0601, 1'b0);
        check24("alarm 0601", 16'h0601);
        sel = 2'b10;
        #1;
        check24("time kept", 16'h1307);
        check("time kept sec", {24'h0, sec12}, 32'd6);
        hold(2'b01, B_MIN, 59);
        check12("alarm 0600", 16'h0600, 1'b0);
        sel = 2'b10;

        // Alarm fires at 06:00 and lasts 30 cycles
        alarm_en = 1'b1;
        set_time(5, 59);
        tick(59);
        check("alarm before", {31'h0, al12}, 32'd0);
        check24("alarm before", 16'h0559);
        tick(1);
        check("alarm fire", {31'h0, al12}, 32'd1);
        check24("alarm fire", 16'h0600);
        check("alarm fire pulse", {31'h0, mp12}, 32'd1);
        tick(29);
        check("alarm cycle30", {31'h0, al12}, 32'd1);
        tick(1);
        check("alarm expired", {31'h0, al12}, 32'd0);
        tick(1);
        check("alarm stays low", {31'h0, al12}, 32'd0);

        // Button cancel in run mode
        set_time(5, 59);
        tick(60);
        check("refire", {31'h0, al12}, 32'd1);
        tick(4);
        check("refire cycle5", {31'h0, al12}, 32'd1);
        hold(2'b10, B_MIN, 1);
        check("btn cancel", {31'h0, al12}, 32'd0);
        check24("btn cancel time", 16'h0600);
        check("btn cancel sec", {24'h0, sec12}, 32'd5);
        tick(1);
        check("cancel stays", {31'h0, al12}, 32'd0);

        // Async reset during an active alarm
        set_time(5, 59);
        tick(60);
        tick(17);
        check("pre rst alarm", {31'h0, al12}, 32'd1);
        check("pre rst sec", {24'h0, sec12}, 32'd17);
        #2 rst = 1'b1;
        #1;
        check("rst alarm", {31'h0, al12}, 32'd0);
        check12("rst time", 16'h1200, 1'b1);
        check24("rst time", 16'h1200);
        check("rst sec", {24'h0, sec12}, 32'd0);
        @(negedge clk1sec);
        rst = 1'b0;
        tick(65);
        check("no refire", {31'h0, al12}, 32'd0);
        check24("post rst run", 16'h1201);
        check("post rst sec", {24'h0, sec12}, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
